// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares the memory_interface CPU port between fetch and data requesters
// Data has priority; a fetch waiting behind MAX_STREAK data grants wins the next arbitration.
module memory_port_arbiter #(
   parameter int MAX_STREAK = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        if_req,
   input  logic [12:0] if_addr,
   output logic        if_ack,
   output logic        if_err,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_load,
   input  logic [12:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [1:0]  d_word_type,
   input  logic        d_is_signed,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] d_rdata,
   output logic [12:0] mi_address,
   output logic [31:0] mi_data_in,
   output logic        mi_load,
   output logic        mi_store,
   output logic [1:0]  mi_word_type,
   output logic        mi_is_signed,
   input  logic [31:0] mi_data_out,
   input  logic        mi_output_valid,
   input  logic        mi_write_ready,
   input  logic        mi_busy,
   output logic        cur_owner
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]  state;
   logic [3:0]  streak;
   logic [7:0]  tcount;
   logic        op_load;

   logic        grant_ok;
   logic        grant_d;
   logic        pre_err;
   logic [3:0]  streak_next;
   logic        complete;
   logic        resp_fire;
   logic        resp_owner;
   logic        resp_err;
   logic [31:0] resp_data;

   always_comb begin
      grant_ok = !mi_busy && (if_req || d_req);
      grant_d  = d_req && !(if_req && streak == 4'(MAX_STREAK));
      pre_err  = grant_d ? (d_word_type == 2'b11) : if_addr[0];
      if (grant_d && if_req)
         streak_next = (streak == 4'(MAX_STREAK)) ? streak : streak + 4'd1;
      else
         streak_next = 4'd0;
      complete = op_load ? mi_output_valid : mi_write_ready;
   end

   // Single place deciding when and what an owner is answered with.
   always_comb begin
      resp_fire  = 1'b0;
      resp_owner = cur_owner;
      resp_err   = 1'b0;
      resp_data  = 32'd0;
      case (state)
         IDLE: begin
            if (grant_ok && pre_err) begin
               resp_fire  = 1'b1;
               resp_owner = grant_d;
               resp_err   = 1'b1;
            end
         end
         WAIT: begin
            if (complete) begin
               resp_fire = 1'b1;
               resp_data = op_load ? mi_data_out : 32'd0;
            end else if (tcount == 8'(TIMEOUT - 1)) begin
               resp_fire = 1'b1;
               resp_err  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         streak       <= 4'd0;
         tcount       <= 8'd0;
         op_load      <= 1'b0;
         cur_owner    <= 1'b0;
         if_ack       <= 1'b0;
         if_err       <= 1'b0;
         if_rdata     <= 32'd0;
         d_ack        <= 1'b0;
         d_err        <= 1'b0;
         d_rdata      <= 32'd0;
         mi_address   <= 13'd0;
         mi_data_in   <= 32'd0;
         mi_load      <= 1'b0;
         mi_store     <= 1'b0;
         mi_word_type <= 2'd0;
         mi_is_signed <= 1'b0;
      end else begin
         if_ack <= 1'b0;
         d_ack  <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_ok) begin
                  cur_owner <= grant_d;
                  streak    <= streak_next;
                  if (pre_err) begin
                     state <= RESP;
                  end else begin
                     state        <= ISSUE;
                     op_load      <= !grant_d || d_load;
                     mi_load      <= !grant_d || d_load;
                     mi_store     <= grant_d && !d_load;
                     mi_address   <= grant_d ? d_addr : if_addr;
                     mi_data_in   <= grant_d ? d_wdata : 32'd0;
                     mi_word_type <= grant_d ? d_word_type : 2'b10;
                     mi_is_signed <= grant_d && d_is_signed;
                  end
               end
            end
            ISSUE: begin
               mi_load  <= 1'b0;
               mi_store <= 1'b0;
               tcount   <= 8'd0;
               state    <= WAIT;
            end
            WAIT: begin
               if (resp_fire) state <= RESP;
               else           tcount <= tcount + 8'd1;
            end
            default: state <= IDLE;
         endcase

         if (resp_fire) begin
            mi_address   <= 13'd0;
            mi_data_in   <= 32'd0;
            mi_word_type <= 2'd0;
            mi_is_signed <= 1'b0;
            if (resp_owner) begin
               d_ack   <= 1'b1;
               d_err   <= resp_err;
               d_rdata <= resp_data;
            end else begin
               if_ack   <= 1'b1;
               if_err   <= resp_err;
               if_rdata <= resp_data;
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - randomized bench with a transaction-timeline reference model
// Each grant is predicted from the arbitration rule and turned into expected strobe/ack cycles.
module tb_memory_port_arbiter;

   localparam int MAX_STREAK = 4;
   localparam int TIMEOUT    = 16;
   localparam int N_CYCLES   = 6000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        if_req = 1'b0;
   logic [12:0] if_addr = '0;
   logic        if_ack, if_err;
   logic [31:0] if_rdata;
   logic        d_req = 1'b0;
   logic        d_load = 1'b0;
   logic [12:0] d_addr = '0;
   logic [31:0] d_wdata = '0;
   logic [1:0]  d_word_type = '0;
   logic        d_is_signed = 1'b0;
   logic        d_ack, d_err;
   logic [31:0] d_rdata;
   logic [12:0] mi_address;
   logic [31:0] mi_data_in;
   logic        mi_load, mi_store;
   logic [1:0]  mi_word_type;
   logic        mi_is_signed;
   logic [31:0] mi_data_out = '0;
   logic        mi_output_valid = 1'b0;
   logic        mi_write_ready = 1'b0;
   logic        mi_busy = 1'b0;
   logic        cur_owner;

   always #5 clk = ~clk;

   memory_port_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
      .d_req(d_req), .d_load(d_load), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_word_type(d_word_type), .d_is_signed(d_is_signed),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .mi_address(mi_address), .mi_data_in(mi_data_in), .mi_load(mi_load), .mi_store(mi_store),
      .mi_word_type(mi_word_type), .mi_is_signed(mi_is_signed), .mi_data_out(mi_data_out),
      .mi_output_valid(mi_output_valid), .mi_write_ready(mi_write_ready), .mi_busy(mi_busy),
      .cur_owner(cur_owner)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_ctl"}, {if_ack, if_err, d_ack, d_err, mi_load, mi_store,
                               mi_word_type, mi_is_signed, cur_owner}, 32'd0);
      check_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
      check_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
      check_eq({tag, "_mi_data_in"}, mi_data_in, 32'd0);
      check_eq({tag, "_mi_address"}, {19'd0, mi_address}, 32'd0);
   endtask

   // Reference model: one outstanding transaction described by its cycle timeline.
   int          cyc, idle_from, streak_m, resets_done;
   bit          busy_tx, tx_owner, tx_pre, tx_load, tx_err, tx_signed;
   int          grant_cyc, issue_cyc, done_cyc, ack_cyc, k;
   logic [12:0] tx_addr;
   logic [31:0] tx_wdata, tx_rdata, resp_data;
   logic [1:0]  tx_type;
   logic [31:0] exp_if_rdata, exp_d_rdata;
   bit          exp_if_err, exp_d_err;
   bit          in_wait, data_wins;
   int          grants_f, grants_d, grants_pre, timeouts;

   initial begin
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b1;
      cyc = 0; idle_from = 1; streak_m = 0; busy_tx = 0; resets_done = 0;
      exp_if_rdata = '0; exp_d_rdata = '0; exp_if_err = 0; exp_d_err = 0;
      grants_f = 0; grants_d = 0; grants_pre = 0; timeouts = 0;

      for (int step = 0; step < N_CYCLES; step++) begin
         @(negedge clk);
         cyc++;

         // Observed outputs reflect the arbiter state during cycle cyc.
         check_eq("if_ack", if_ack, busy_tx && cyc == ack_cyc && !tx_owner);
         check_eq("d_ack", d_ack, busy_tx && cyc == ack_cyc && tx_owner);
         if (busy_tx && cyc == ack_cyc) begin
            if (tx_owner) begin exp_d_err = tx_err; exp_d_rdata = tx_rdata; end
            else          begin exp_if_err = tx_err; exp_if_rdata = tx_rdata; end
         end
         check_eq("if_err", if_err, exp_if_err);
         check_eq("if_rdata", if_rdata, exp_if_rdata);
         check_eq("d_err", d_err, exp_d_err);
         check_eq("d_rdata", d_rdata, exp_d_rdata);
         check_eq("mi_load", mi_load, busy_tx && !tx_pre && cyc == issue_cyc && tx_load);
         check_eq("mi_store", mi_store, busy_tx && !tx_pre && cyc == issue_cyc && !tx_load);
         if (busy_tx && cyc > grant_cyc)
            check_eq("cur_owner", cur_owner, tx_owner);
         if (busy_tx && !tx_pre && cyc >= issue_cyc && cyc < ack_cyc) begin
            check_eq("mi_address", mi_address, tx_addr);
            check_eq("mi_data_in", mi_data_in, tx_wdata);
            check_eq("mi_type_sign", {mi_word_type, mi_is_signed}, {tx_type, tx_signed});
         end
         if (!busy_tx && cyc >= idle_from)
            check_eq("mi_idle", {mi_address, mi_word_type, mi_is_signed, mi_load, mi_store},
                     32'd0);
         if (!busy_tx && cyc >= idle_from)
            check_eq("mi_idle_data", mi_data_in, 32'd0);

         if (busy_tx && cyc == ack_cyc) begin
            if (tx_owner) d_req = 1'b0; else if_req = 1'b0;
            busy_tx = 0;
            idle_from = cyc + 1;
         end

         in_wait = busy_tx && !tx_pre && cyc >= issue_cyc + 1 && cyc < ack_cyc;

         // Occasional reset in the middle of a WAIT.
         if (in_wait && resets_done < 8 && $urandom_range(0, 59) == 0) begin
            resets_done++;
            reset = 1'b0;
            #1;
            check_all_zero("async_reset");
            if_req = 1'b0; d_req = 1'b0;
            mi_output_valid = 1'b0; mi_write_ready = 1'b0; mi_busy = 1'b0;
            @(negedge clk);
            cyc++;
            check_all_zero("held_reset");
            reset = 1'b1;
            busy_tx = 0; idle_from = cyc + 1; streak_m = 0;
            exp_if_rdata = '0; exp_d_rdata = '0; exp_if_err = 0; exp_d_err = 0;
            continue;
         end

         // Memory responder: real completion plus pulses the arbiter must ignore.
         mi_data_out = $urandom;
         mi_output_valid = 1'b0;
         mi_write_ready = 1'b0;
         if (in_wait && cyc == done_cyc) begin
            mi_data_out = resp_data;
            if (tx_load) mi_output_valid = 1'b1; else mi_write_ready = 1'b1;
         end else if (in_wait) begin
            if ($urandom_range(0, 3) == 0) begin
               if (tx_load) mi_write_ready = 1'b1; else mi_output_valid = 1'b1;
            end
         end else begin
            mi_output_valid = ($urandom_range(0, 3) == 0);
            mi_write_ready  = ($urandom_range(0, 3) == 0);
         end
         mi_busy = ($urandom_range(0, 4) == 0);

         // Requesters: new requests; fields of pending ones may wander while the port is busy.
         if (!if_req && $urandom_range(0, 2) != 0) begin
            if_req = 1'b1;
            if_addr = 13'($urandom);
            if ($urandom_range(0, 4) != 0) if_addr[0] = 1'b0;
         end else if (if_req && busy_tx && tx_owner && $urandom_range(0, 3) == 0) begin
            if_addr = 13'($urandom);
         end
         if ((!d_req && $urandom_range(0, 2) != 0) ||
             (d_req && busy_tx && !tx_owner && $urandom_range(0, 3) == 0)) begin
            d_req = 1'b1;
            d_load = 1'($urandom);
            d_addr = 13'($urandom);
            d_wdata = $urandom;
            d_word_type = 2'($urandom);
            d_is_signed = 1'($urandom);
         end

         // Grant prediction for the arbitration evaluated at the end of this cycle.
         if (!busy_tx && cyc >= idle_from && !mi_busy && (if_req || d_req)) begin
            data_wins = d_req && !(if_req && streak_m >= MAX_STREAK);
            if (data_wins && if_req) streak_m = (streak_m < MAX_STREAK) ? streak_m + 1 : MAX_STREAK;
            else                     streak_m = 0;
            busy_tx   = 1;
            grant_cyc = cyc;
            issue_cyc = cyc + 1;
            tx_owner  = data_wins;
            if (data_wins) begin
               grants_d++;
               tx_pre = (d_word_type == 2'b11);
               tx_load = d_load; tx_addr = d_addr; tx_wdata = d_wdata;
               tx_type = d_word_type; tx_signed = d_is_signed;
            end else begin
               grants_f++;
               tx_pre = if_addr[0];
               tx_load = 1; tx_addr = if_addr; tx_wdata = 32'd0;
               tx_type = 2'b10; tx_signed = 0;
            end
            done_cyc = -1;
            if (tx_pre) begin
               grants_pre++;
               ack_cyc = cyc + 1; tx_err = 1; tx_rdata = 32'd0;
            end else begin
               k = ($urandom_range(0, 4) != 0) ? $urandom_range(0, 5) : $urandom_range(0, TIMEOUT + 3);
               if (k <= TIMEOUT - 1) begin
                  done_cyc  = cyc + 2 + k;
                  ack_cyc   = done_cyc + 1;
                  resp_data = $urandom;
                  tx_err    = 0;
                  tx_rdata  = tx_load ? resp_data : 32'd0;
               end else begin
                  timeouts++;
                  ack_cyc  = cyc + 2 + TIMEOUT;
                  tx_err   = 1;
                  tx_rdata = 32'd0;
               end
            end
         end
      end

      $display("grants fetch=%0d data=%0d precheck=%0d timeouts=%0d resets=%0d",
               grants_f, grants_d, grants_pre, timeouts, resets_done);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the CPU-side port of the 16-bit-memory interface between two requesters: instruction fetch (read-only, word) and data access (load/store, byte/halfword/word).
- Arbitrates with data priority plus a fetch anti-starvation limit.
- Sequences each access as a one-cycle load/store pulse followed by a completion wait, with timeout.
- Returns read data and errors to the owning requester.
- Sits between the CPU fetch/execute stages and memory_interface.

Parameters:
MAX_STREAK, 4, max consecutive data grants while fetch is pending (legal 1..15)
TIMEOUT, 16, WAIT cycles before an access is aborted with error (legal 2..255)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held until if_ack
if_addr  in  13  fetch byte address
if_ack  out  1  one-cycle fetch completion pulse
if_err  out  1  valid with if_ack: misaligned or timed out
if_rdata  out  32  fetch data, valid with if_ack
d_req  in  1  data request, held until d_ack
d_load  in  1  1 = load, 0 = store
d_addr  in  13  data byte address
d_wdata  in  32  store data
d_word_type  in  2  00 byte, 01 halfword, 10 word, 11 illegal
d_is_signed  in  1  sign-extend load
d_ack  out  1  one-cycle data completion pulse
d_err  out  1  valid with d_ack: illegal type or timed out
d_rdata  out  32  load data, valid with d_ack; 0 for stores
mi_address  out  13  to memory_interface address
mi_data_in  out  32  to memory_interface data_in
mi_load  out  1  one-cycle load strobe
mi_store  out  1  one-cycle store strobe
mi_word_type  out  2  to memory_interface word_type
mi_is_signed  out  1  to memory_interface is_signed
mi_data_out  in  32  from memory_interface data_out
mi_output_valid  in  1  load complete
mi_write_ready  in  1  store complete
mi_busy  in  1  memory_interface busy
cur_owner  out  1  0 = fetch, 1 = data; meaningful outside IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- Reset (reset low, async): state IDLE, streak counter 0, timeout counter 0. All outputs 0, including rdata, ack, err, mi_* and cur_owner.
- IDLE: evaluates a grant only when !mi_busy and at least one req is high.
  - Grant goes to data if d_req && !(if_req && streak==MAX_STREAK); otherwise to fetch.
  - At grant, the owner's fields are latched into the mi_* registers. Fetch uses mi_word_type=10, mi_is_signed=0, mi_data_in=0.
  - cur_owner is set to the grantee.
- Streak counter:
  - Increments on a data grant while if_req=1.
  - Clears on a fetch grant, or on a data grant with if_req=0.
  - Saturates at MAX_STREAK.
- Pre-check at grant:
  - A fetch with if_addr[0]=1, or a data request with d_word_type=11, goes IDLE->RESP directly with err=1 and rdata=0.
  - No mi_load/mi_store is issued.
  - The streak counter still updates as for a normal grant.
- ISSUE: mi_load (owner load) or mi_store (data store) is high for exactly this one cycle, then WAIT. The timeout counter clears.
- WAIT:
  - mi_address, mi_data_in, mi_word_type and mi_is_signed stay stable; strobes are low.
  - A load completes on mi_output_valid: mi_data_out is captured into the owner's rdata.
  - A store completes on mi_write_ready: rdata is set to 0.
  - On completion, go to RESP with err=0.
  - Otherwise the counter increments. At counter==TIMEOUT-1 without completion, go to RESP with err=1 and rdata=0.
  - Completion and timeout in the same cycle: completion wins.
- RESP:
  - The owner's ack is high for exactly this cycle; err and rdata are valid in the same cycle.
  - The non-owner's ack, err and rdata are unchanged (0 for ack).
  - Next state is IDLE; mi_* return to 0.
- Requester rule: req drops at the edge where ack=1 is sampled. The arbiter never re-grants the same request. In IDLE after RESP, req is assumed fresh.
- Latency:
  - Req seen in IDLE at cycle 0, ISSUE at 1, first WAIT at 2. If completion arrives at 2, ack is at 3 (minimum 3 cycles).
  - Pre-check error: ack at cycle 1.
- Completion pulses arriving in IDLE, ISSUE or RESP are ignored.
- Request changes while not in IDLE are ignored; fields are latched only at grant.
- Reset mid-access: immediate return to IDLE with all outputs 0. No ack is produced for the aborted access.

Test Plan:
- d_req load, d_addr=13'h0005, type 01, signed; mi_output_valid in the first WAIT cycle with mi_data_out=32'hFFFF8001 -> mi_load pulse at cycle 1; d_ack, d_err=0, d_rdata=32'hFFFF8001 at cycle 3.
- if_req and d_req both held, back-to-back, MAX_STREAK=4 -> grant order D,D,D,D,F,D,D,D,D,F; cur_owner matches.
- if_req with if_addr=13'h0003 -> if_ack and if_err=1 at cycle 1, if_rdata=0, no mi_load ever asserted.
- d_req store, d_wdata=32'hDEADBEEF, no mi_write_ready, TIMEOUT=16 -> mi_store for one cycle, mi_data_in held at 32'hDEADBEEF; d_ack with d_err=1 after 16 WAIT cycles.
- mi_busy=1 for 5 cycles with d_req high -> no grant until mi_busy falls; ISSUE in the cycle after the first IDLE with mi_busy=0.
- reset asserted during WAIT of a fetch -> all outputs 0 immediately, no if_ack. After release, a new fetch completes normally.
